status_frame_receiver: RTL and testbench

//  Downstream consumer of the main alarm FSM's serial status link (STATUS_SEND/STATUS_OUT).

---
 rtl/status_frame_receiver.sv | 225 ++++++++++++++++++++++
 tb/tb_status_frame_receiver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : status_frame_receiver
// Purpose  : Receives the serial status link from the main alarm board.
//            It rebuilds each MSG_W-bit status frame from the bit stream,
//            rejects frames that are too short or too long, and holds the
//            flags from the last good frame so the LEDs can show them.
//            A watchdog raises LINK_LOST when no good frame has arrived for
//            a while.
// Ports    : CLK          serial clock shared with the main board (posedge)
//            RST          synchronous, active-high reset
//            STATUS_SEND  frame enable, high for MSG_W cycles per frame
//            STATUS_IN    frame data, LSB first, one bit per SEND cycle
//            ARMED        flag from bit 0 of the last valid frame
//            ALARM        flag from bit 1 of the last valid frame
//            SENSOR1      flag from bit 2 of the last valid frame
//            SENSOR2      flag from bit 3 of the last valid frame
//            FRAME_OK     one-cycle pulse when a valid frame is accepted
//            FRAME_ERR    one-cycle pulse when a short or overlong frame is
//                         rejected
//            ERR_COUNT    saturating count of FRAME_ERR pulses
//            LINK_LOST    high when no valid frame has arrived for TIMEOUT
//                         cycles, or none since reset
// Options  : STATUS_CONFIRM_EN - when defined, the flags change only when two
//            valid frames in a row carry the same payload.
// Revision : 1.0 - initial release
// ============================================================================
module status_frame_receiver #(
  parameter int MSG_W   = 4,   // data bits per frame (flag mapping needs >= 4)
  parameter int TIMEOUT = 64,  // idle cycles before LINK_LOST (>= MSG_W+2)
  parameter int ERR_W   = 8    // frame-error counter width
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STATUS_SEND,
  input  logic             STATUS_IN,
  output logic             ARMED,
  output logic             ALARM,
  output logic             SENSOR1,
  output logic             SENSOR2,
  output logic             FRAME_OK,
  output logic             FRAME_ERR,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic             LINK_LOST
);

  localparam int c_cnt_w = $clog2(MSG_W + 1);
  localparam int c_wd_w  = $clog2(TIMEOUT + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(MSG_W);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_wd_w-1:0]  c_wd_max   = c_wd_w'(TIMEOUT);
  localparam logic [c_wd_w-1:0]  c_wd_one   = c_wd_w'(1);
  localparam logic [ERR_W-1:0]   c_err_max  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]   c_err_one  = ERR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;          // bits captured so far
  logic [MSG_W-1:0]   sr_q, sr_d;            // frame under assembly
  logic [MSG_W-1:0]   flags_q, flags_d;      // last accepted payload
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [c_wd_w-1:0]  wd_q, wd_d;            // cycles since last FRAME_OK
  logic               seen_q, seen_d;        // a valid frame arrived since reset
  logic               link_lost_q, link_lost_d;

`ifdef STATUS_CONFIRM_EN
  logic [MSG_W-1:0]   prev_q, prev_d;        // payload of previous valid frame
  logic               prev_vld_q, prev_vld_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    flags_d     = flags_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef STATUS_CONFIRM_EN
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (STATUS_SEND) begin
          // Stale upper bits of sr are harmless: a frame is only accepted
          // once every position has been overwritten.
          sr_d[0] = STATUS_IN;
          cnt_d   = c_cnt_one;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (STATUS_SEND) begin
          if (cnt_q < c_cnt_full) begin
            for (int i = 0; i < MSG_W; i++) begin
              if (cnt_q == c_cnt_w'(i)) begin
                sr_d[i] = STATUS_IN;
              end
            end
            cnt_d = cnt_q + c_cnt_one;
          end else begin
            // One bit too many: report once, then swallow the rest of the burst.
            frame_err_d = 1'b1;
            state_d     = S_DISCARD;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (cnt_q == c_cnt_full) begin
            frame_ok_d = 1'b1;
`ifdef STATUS_CONFIRM_EN
            // Only a payload seen twice in a row reaches the LEDs.
            if (prev_vld_q && (sr_q == prev_q)) begin
              flags_d = sr_q;
            end
            prev_d     = sr_q;
            prev_vld_d = 1'b1;
`else
            flags_d = sr_q;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      S_DISCARD: begin
        if (!STATUS_SEND) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Error counter sticks at all-ones rather than wrapping back to a small value.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != c_err_max)) begin
      err_cnt_d = err_cnt_q + c_err_one;
    end
  end

  // Watchdog is evaluated from the same next-state as FRAME_OK so that
  // LINK_LOST falls in the very cycle FRAME_OK rises.
  always_comb begin
    wd_d = wd_q;
    if (frame_ok_d) begin
      wd_d = '0;
    end else if (wd_q != c_wd_max) begin
      wd_d = wd_q + c_wd_one;
    end
    seen_d      = seen_q | frame_ok_d;
    link_lost_d = ~seen_d | (wd_d == c_wd_max);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      flags_q     <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      wd_q        <= '0;
      seen_q      <= 1'b0;
      link_lost_q <= 1'b1;
`ifdef STATUS_CONFIRM_EN
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      flags_q     <= flags_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      wd_q        <= wd_d;
      seen_q      <= seen_d;
      link_lost_q <= link_lost_d;
`ifdef STATUS_CONFIRM_EN
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ARMED     = flags_q[0];
  assign ALARM     = flags_q[1];
  assign SENSOR1   = flags_q[2];
  assign SENSOR2   = flags_q[3];
  assign FRAME_OK  = frame_ok_q;
  assign FRAME_ERR = frame_err_q;
  assign ERR_COUNT = err_cnt_q;
  assign LINK_LOST = link_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_status_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_frame_receiver
// Purpose  : Self-checking bench for status_frame_receiver. Frames are
//            described in a vector table; each driven frame pushes its
//            expected outcome into a queue that a negedge monitor pops on
//            every FRAME_OK / FRAME_ERR pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_frame_receiver;

  localparam int MSG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int ERR_W   = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             STATUS_SEND;
  logic             STATUS_IN;
  logic             ARMED, ALARM, SENSOR1, SENSOR2;
  logic             FRAME_OK, FRAME_ERR;
  logic [ERR_W-1:0] ERR_COUNT;
  logic             LINK_LOST;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ok;
    logic       err;
    logic [3:0] flags;
  } exp_t;

  typedef struct {
    int         nbits;
    logic [7:0] bits;
    int         gap;
    logic       e_ok;
    logic       e_err;
  } vec_t;

  exp_t       q[$];
  vec_t       vecs[10];
  logic [3:0] m_flags    = 4'h0;
  logic [3:0] m_prev     = 4'h0;
  logic       m_prev_vld = 1'b0;
  int         m_err      = 0;

  status_frame_receiver #(
    .MSG_W   (MSG_W),
    .TIMEOUT (TIMEOUT),
    .ERR_W   (ERR_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .STATUS_SEND (STATUS_SEND),
    .STATUS_IN   (STATUS_IN),
    .ARMED       (ARMED),
    .ALARM       (ALARM),
    .SENSOR1     (SENSOR1),
    .SENSOR2     (SENSOR2),
    .FRAME_OK    (FRAME_OK),
    .FRAME_ERR   (FRAME_ERR),
    .ERR_COUNT   (ERR_COUNT),
    .LINK_LOST   (LINK_LOST)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one burst of n bits followed by gap idle cycles, after queuing the
  // outcome it should produce.
  task automatic send_bits(input int n, input logic [7:0] bits, input int gap,
                           input logic e_ok, input logic e_err);
    exp_t e;
    if (e_ok) begin
`ifdef STATUS_CONFIRM_EN
      if (m_prev_vld && (m_prev == bits[3:0])) m_flags = bits[3:0];
      m_prev     = bits[3:0];
      m_prev_vld = 1'b1;
`else
      m_flags = bits[3:0];
`endif
    end
    e.ok    = e_ok;
    e.err   = e_err;
    e.flags = m_flags;
    if (e_ok || e_err) q.push_back(e);
    for (int i = 0; i < n; i++) begin
      STATUS_SEND = 1'b1;
      STATUS_IN   = bits[i];
      tick();
    end
    STATUS_SEND = 1'b0;
    STATUS_IN   = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (FRAME_OK || FRAME_ERR)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual ok=%0b err=%0b required no pulse", FRAME_OK, FRAME_ERR);
      end else begin
        e = q.pop_front();
        chk("sb_frame_ok", {31'd0, FRAME_OK}, {31'd0, e.ok});
        chk("sb_frame_err", {31'd0, FRAME_ERR}, {31'd0, e.err});
        chk("sb_flags", {28'd0, SENSOR2, SENSOR1, ALARM, ARMED}, {28'd0, e.flags});
        if (e.err && (m_err < 255)) m_err++;
        chk("sb_err_count", {24'd0, ERR_COUNT}, m_err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    exp_t e;
    vecs = '{
      '{4, 8'h03, 1, 1'b1, 1'b0},
      '{4, 8'h08, 1, 1'b1, 1'b0},
      '{4, 8'h08, 2, 1'b1, 1'b0},
      '{2, 8'h00, 1, 1'b0, 1'b1},
      '{5, 8'h1F, 1, 1'b0, 1'b1},
      '{4, 8'h0E, 3, 1'b1, 1'b0},
      '{1, 8'h01, 1, 1'b0, 1'b1},
      '{4, 8'h0F, 1, 1'b1, 1'b0},
      '{7, 8'h55, 1, 1'b0, 1'b1},
      '{4, 8'h06, 2, 1'b1, 1'b0}
    };

    // Reset values
    RST = 1'b1; STATUS_SEND = 1'b0; STATUS_IN = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_flags", {28'd0, SENSOR2, SENSOR1, ALARM, ARMED}, 32'h0);
    chk("rst_frame_ok", {31'd0, FRAME_OK}, 32'h0);
    chk("rst_frame_err", {31'd0, FRAME_ERR}, 32'h0);
    chk("rst_err_count", {24'd0, ERR_COUNT}, 32'h0);
    chk("rst_link_lost", {31'd0, LINK_LOST}, 32'h1);
    tick();

    // First valid frame: IN=1,0,1,0
    send_bits(4, 8'h05, 0, 1'b1, 1'b0);
    chk("link_lost_before_ok", {31'd0, LINK_LOST}, 32'h1);
    tick();
    chk("first_frame_ok", {31'd0, FRAME_OK}, 32'h1);
    chk("first_link_lost", {31'd0, LINK_LOST}, 32'h0);
    chk("first_armed", {31'd0, ARMED}, {31'd0, m_flags[0]});
    chk("first_alarm", {31'd0, ALARM}, {31'd0, m_flags[1]});
    chk("first_sensor1", {31'd0, SENSOR1}, {31'd0, m_flags[2]});
    chk("first_sensor2", {31'd0, SENSOR2}, {31'd0, m_flags[3]});
    tick();
    chk("first_ok_single", {31'd0, FRAME_OK}, 32'h0);

    // Short frame
    send_bits(3, 8'h07, 0, 1'b0, 1'b1);
    tick();
    chk("short_err", {31'd0, FRAME_ERR}, 32'h1);
    chk("short_err_count", {24'd0, ERR_COUNT}, 32'h1);
    chk("short_flags_kept", {28'd0, SENSOR2, SENSOR1, ALARM, ARMED}, {28'd0, m_flags});
    tick();

    // Overlong frame: error on the 5th sample, then silence until SEND falls
    e.ok = 1'b0; e.err = 1'b1; e.flags = m_flags;
    q.push_back(e);
    for (int i = 0; i < 6; i++) begin
      STATUS_SEND = 1'b1;
      STATUS_IN   = i[0];
      tick();
      if (i == 4) chk("overlong_err_5th", {31'd0, FRAME_ERR}, 32'h1);
      if (i == 5) chk("overlong_err_once", {31'd0, FRAME_ERR}, 32'h0);
    end
    STATUS_SEND = 1'b0;
    tick();
    chk("discard_exit_no_err", {31'd0, FRAME_ERR}, 32'h0);
    send_bits(4, 8'h0A, 1, 1'b1, 1'b0);
    chk("after_discard_ok", {31'd0, FRAME_OK}, 32'h1);

    // Table-driven frames
    for (int v = 0; v < 10; v++) begin
      send_bits(vecs[v].nbits, vecs[v].bits, vecs[v].gap, vecs[v].e_ok, vecs[v].e_err);
      chk("vec_flags", {28'd0, SENSOR2, SENSOR1, ALARM, ARMED}, {28'd0, m_flags});
    end

    // Watchdog timing
    send_bits(4, 8'h09, 1, 1'b1, 1'b0);
    chk("wd_cleared", {31'd0, LINK_LOST}, 32'h0);
    repeat (TIMEOUT - 1) tick();
    chk("wd_not_yet", {31'd0, LINK_LOST}, 32'h0);
    tick();
    chk("wd_expired", {31'd0, LINK_LOST}, 32'h1);
    repeat (10) tick();
    chk("wd_held", {31'd0, LINK_LOST}, 32'h1);
    send_bits(4, 8'h09, 1, 1'b1, 1'b0);
    chk("wd_recovered", {31'd0, LINK_LOST}, 32'h0);

    // Error counter saturation
    for (int k = 0; k < 300; k++) send_bits(2, 8'h03, 1, 1'b0, 1'b1);
    chk("err_saturated", {24'd0, ERR_COUNT}, 32'd255);

    // Reset in the middle of a frame
    STATUS_SEND = 1'b1; STATUS_IN = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    q.delete();
    m_flags = 4'h0; m_prev_vld = 1'b0; m_err = 0;
    chk("midrst_flags", {28'd0, SENSOR2, SENSOR1, ALARM, ARMED}, 32'h0);
    chk("midrst_frame_ok", {31'd0, FRAME_OK}, 32'h0);
    chk("midrst_frame_err", {31'd0, FRAME_ERR}, 32'h0);
    chk("midrst_err_count", {24'd0, ERR_COUNT}, 32'h0);
    chk("midrst_link_lost", {31'd0, LINK_LOST}, 32'h1);
    send_bits(1, 8'h01, 2, 1'b0, 1'b1);
    chk("midrst_tail_err_count", {24'd0, ERR_COUNT}, 32'h1);
    chk("midrst_tail_link_lost", {31'd0, LINK_LOST}, 32'h1);

    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
